dmem_port: RTL and testbench

Data-memory access stage sitting directly downstream of the pipelined CPU's MEM stage. It takes the raw memory request (address, store data, size flags, write strobe) and turns it into an aligned, word-wide, byte-enabled request on a handshaked memory bus. It returns right-justified load data to the MEM/WB register and asserts `busy` so the pipeline freezes until the access completes. All sub-word sign/zero extension stays in write-back; this block only positions bytes.

---
 rtl/dmem_pkg.sv | 34 +++
 rtl/dmem_lane.sv | 59 +++++
 rtl/dmem_port.sv | 196 +++++++++++++++++++
 tb/tb_dmem_port.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory port.
// Holds the FSM state encoding, the access-size encoding and the big-endian lane-enable constants.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // Big-endian lanes: lane 0 (offset 0) is bit 3 of the enable and bits [31:24] of the data.
    localparam logic [3:0] BE_BYTE0   = 4'b1000;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Collapses the MEM-stage size flags into one size code; no flag set means a word access.
    function automatic size_e decode_size(input logic sb, input logic sh,
                                          input logic lb, input logic lh);
        decode_size = SZ_WORD;
        if (sb | lb) begin
            decode_size = SZ_BYTE;
        end else if (sh | lh) begin
            decode_size = SZ_HALF;
        end
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: purely combinational byte-lane steering for the data-memory port.
// Request side: byte enables, store-data replication and the alignment check.
// Load side: extracts the addressed byte/half from bus read data, right-justified, upper bits zero.
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_off_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        aligned_o,
    output logic [31:0] ld_data_o
);

    // Map size and offset to lane enables, replicated store data and the aligned flag.
    always_comb begin
        // NOTE: every output is given a default before the case, so no path can infer a latch.
        be_o      = BE_WORD;
        wdata_o   = req_wdata_i;
        aligned_o = (req_off_i == 2'b00);
        case (req_size_i)
            SZ_BYTE: begin
                be_o      = BE_BYTE0 >> req_off_i;
                wdata_o   = {4{req_wdata_i[7:0]}};
                aligned_o = 1'b1;
            end
            SZ_HALF: begin
                be_o      = req_off_i[1] ? BE_HALF_LO : BE_HALF_HI;
                wdata_o   = {2{req_wdata_i[15:0]}};
                aligned_o = ~req_off_i[0];
            end
            default: ;
        endcase
    end

    // Shift the addressed byte or half of the returned word down to bit 0.
    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_size_i)
            SZ_BYTE: begin
                case (ld_off_i)
                    2'd0:    ld_data_o = {24'b0, ld_rdata_i[31:24]};
                    2'd1:    ld_data_o = {24'b0, ld_rdata_i[23:16]};
                    2'd2:    ld_data_o = {24'b0, ld_rdata_i[15:8]};
                    default: ld_data_o = {24'b0, ld_rdata_i[7:0]};
                endcase
            end
            SZ_HALF: begin
                ld_data_o = ld_off_i[1] ? {16'b0, ld_rdata_i[15:0]} : {16'b0, ld_rdata_i[31:16]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_port.sv
// dmem_port: turns MEM-stage load/store requests into aligned, byte-enabled, handshaked bus accesses
// and freezes the pipeline (busy) until each access completes. Sign/zero extension is left to write-back.
// Optional feature: define DMEM_STORE_BUF_EN to add a one-entry posted-store buffer.
module dmem_port
    import dmem_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    input  logic        mem_wr,
    input  logic        mem_sb,
    input  logic        mem_sh,
    input  logic        mem_lb,
    input  logic        mem_lh,
    output logic [31:0] mem_read_data,
    output logic        busy,
    output logic        align_err,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int unsigned      CNT_W     = (WAIT_LIMIT > 255) ? $clog2(WAIT_LIMIT + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [29:0]      addr_q;
    logic [3:0]       be_q;
    logic [31:0]      wdata_q;
    logic             we_q;
    logic [1:0]       ld_size_q;
    logic [1:0]       ld_off_q;
    logic [31:0]      rdata_q;
    logic             align_err_q;
    logic             bus_err_q;
    logic             bus_req_q;

    logic [1:0]       req_size;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata;
    logic             lane_aligned;
    logic [31:0]      lane_ld_data;

    logic             in_idle, in_access;
    logic             accept, misalign, ack_done, timeout;
    logic             post_now, posted_q;

    assign req_size = decode_size(mem_sb, mem_sh, mem_lb, mem_lh);

    dmem_lane u_lane (
        .req_size_i  (req_size),
        .req_off_i   (mem_addr[1:0]),
        .req_wdata_i (mem_write_data),
        .ld_size_i   (ld_size_q),
        .ld_off_i    (ld_off_q),
        .ld_rdata_i  (bus_rdata),
        .be_o        (lane_be),
        .wdata_o     (lane_wdata),
        .aligned_o   (lane_aligned),
        .ld_data_o   (lane_ld_data)
    );

    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);
    assign accept    = in_idle & req_valid & lane_aligned;
    assign misalign  = in_idle & req_valid & ~lane_aligned;
    assign ack_done  = in_access & bus_ack;

    // The wait counter saturates; an ack in the limit cycle wins over the timeout.
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timeout   = in_access & ~bus_ack & (cnt_inc >= CNT_LIMIT);

`ifdef DMEM_STORE_BUF_EN
    // An aligned store accepted from IDLE is posted: the pipeline moves on while it drains.
    assign post_now = accept & mem_wr;

    // Remember whether the in-flight access is a posted store the pipeline has already passed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            posted_q <= 1'b0;
        end else if (accept) begin
            posted_q <= post_now;
        end
    end
`else
    assign post_now = 1'b0;
    assign posted_q = 1'b0;
`endif

    // Freeze the pipeline while a blocking access is accepted or in flight, or while a new
    // request waits behind a posted-store drain; reset drops it immediately.
    assign busy = reset & ((accept & ~post_now) | (in_access & (~posted_q | req_valid)));

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end
            end
            ST_ACCESS: begin
                if (ack_done || timeout) begin
                    // A posted drain has no pipeline step to release, so it skips DONE.
                    state_d = posted_q ? ST_IDLE : ST_DONE;
                end
                if (!bus_ack) begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM state, wait counter and the registered bus request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bus_req_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_req_q <= (state_d == ST_ACCESS);
        end
    end

    // Latch the aligned request on acceptance; it stays stable for the whole bus access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            ld_size_q <= SZ_WORD;
            ld_off_q  <= 2'b00;
        end else if (accept) begin
            addr_q    <= mem_addr[31:2];
            be_q      <= lane_be;
            wdata_q   <= lane_wdata;
            we_q      <= mem_wr;
            ld_size_q <= req_size;
            ld_off_q  <= mem_addr[1:0];
        end
    end

    // Load result register: captures on ack, cleared on timeout or a misaligned load, else holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (ack_done && !we_q) begin
            rdata_q <= lane_ld_data;
        end else if (timeout && !posted_q) begin
            rdata_q <= '0;
        end else if (misalign && !mem_wr) begin
            rdata_q <= '0;
        end
    end

    // One-cycle error pulses, visible the cycle after the offending event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            align_err_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            align_err_q <= misalign;
            bus_err_q   <= timeout;
        end
    end

    assign mem_read_data = rdata_q;
    assign align_err     = align_err_q;
    assign bus_err       = bus_err_q;
    assign bus_req       = bus_req_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_wdata     = wdata_q;
    assign bus_be        = be_q;

endmodule

// File: tb/tb_dmem_port.sv
// tb_dmem_port: randomized self-checking bench for dmem_port (default build, WAIT_LIMIT = 4).
// A transaction-level model predicts every cycle's outputs; one compare process checks them.
module tb_dmem_port;

    localparam int L = 4;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_wr, mem_sb, mem_sh, mem_lb, mem_lh;
    logic [31:0] mem_read_data;
    logic        busy, align_err, bus_err, bus_req, bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    dmem_port #(.WAIT_LIMIT(L)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_wr         (mem_wr),
        .mem_sb         (mem_sb),
        .mem_sh         (mem_sh),
        .mem_lb         (mem_lb),
        .mem_lh         (mem_lh),
        .mem_read_data  (mem_read_data),
        .busy           (busy),
        .align_err      (align_err),
        .bus_err        (bus_err),
        .bus_req        (bus_req),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_be         (bus_be),
        .bus_ack        (bus_ack),
        .bus_rdata      (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Expected outputs for one clock cycle.
    typedef struct packed {
        logic        busy;
        logic        bus_req;
        logic        align_err;
        logic        bus_err;
        logic        chk_bus;
        logic        chk_wdata;
        logic        we;
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_rdata = '0;   // model of the held load result

    // Observations of the last transaction, used for the literal expectations.
    int          obs_busy;
    logic        obs_req, obs_align, obs_berr, obs_we;
    logic [29:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata, obs_data;

    // The single compare process: one model record per cycle, checked mid-cycle.
    exp_t cur;
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("busy",          32'(busy),      32'(cur.busy));
            check("bus_req",       32'(bus_req),   32'(cur.bus_req));
            check("align_err",     32'(align_err), 32'(cur.align_err));
            check("bus_err",       32'(bus_err),   32'(cur.bus_err));
            check("mem_read_data", mem_read_data,  cur.data);
            if (cur.chk_bus) begin
                check("bus_addr", 32'(bus_addr), 32'(cur.addr));
                check("bus_be",   32'(bus_be),   32'(cur.be));
                check("bus_we",   32'(bus_we),   32'(cur.we));
            end
            if (cur.chk_wdata) begin
                check("bus_wdata", bus_wdata, cur.wdata);
            end
        end
    end

    task automatic idle_cycle();
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = $urandom();
        e = '0;
        e.data = exp_rdata;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // One request. size: 0 byte, 1 half, 2 word. d: ack arrives on the d-th bus_req cycle;
    // d > L means the bus never answers within the wait limit.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wd, input logic wr,
                           input int size, input logic [31:0] rd, input int d);
        logic [1:0]  off;
        bit          ok;
        int          n, ncyc;
        logic [3:0]  be;
        logic [31:0] wexp, res;
        exp_t        e;
        off = addr[1:0];
        ok  = (size == 0) || (size == 1 && !off[0]) || (size == 2 && off == 2'b00);
        if (size == 0) begin
            be   = 4'b1000 >> off;
            wexp = {24'b0, wd[7:0]} * 32'h0101_0101;
            res  = (rd >> (8 * (3 - int'(off)))) & 32'h0000_00FF;
        end else if (size == 1) begin
            be   = off[1] ? 4'b0011 : 4'b1100;
            wexp = {16'b0, wd[15:0]} * 32'h0001_0001;
            res  = off[1] ? (rd & 32'h0000_FFFF) : (rd >> 16);
        end else begin
            be   = 4'b1111;
            wexp = wd;
            res  = rd;
        end
        n = (d <= L) ? d : L;

        @(posedge clk); #1;
        if (!ok) begin
            e = '0; e.data = exp_rdata;
            exp_q.push_back(e);
            if (!wr) exp_rdata = '0;
            e = '0; e.align_err = 1'b1; e.data = exp_rdata;
            exp_q.push_back(e);
            ncyc = 2;
        end else begin
            e = '0; e.busy = 1'b1; e.data = exp_rdata;
            exp_q.push_back(e);
            for (int c = 1; c <= n; c++) begin
                e = '0;
                e.busy = 1'b1; e.bus_req = 1'b1; e.chk_bus = 1'b1; e.chk_wdata = wr;
                e.addr = addr[31:2]; e.be = be; e.we = wr; e.wdata = wexp; e.data = exp_rdata;
                exp_q.push_back(e);
            end
            if (d > L) exp_rdata = '0;
            else if (!wr) exp_rdata = res;
            e = '0; e.bus_err = (d > L); e.data = exp_rdata;
            exp_q.push_back(e);
            ncyc = n + 2;
        end

        obs_busy = 0; obs_req = 0; obs_align = 0; obs_berr = 0;
        obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 0; obs_data = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            req_valid      = ok ? 1'b1 : (c == 0);
            mem_addr       = addr;
            mem_write_data = wd;
            mem_wr         = wr;
            mem_sb         = wr && size == 0;
            mem_lb         = !wr && size == 0;
            mem_sh         = wr && size == 1;
            mem_lh         = !wr && size == 1;
            bus_ack        = ok && d <= L && c == d;
            bus_rdata      = (c == d) ? rd : $urandom();
            @(negedge clk);
            if (busy) obs_busy++;
            if (bus_req && !obs_req) begin
                obs_addr = bus_addr; obs_be = bus_be; obs_wdata = bus_wdata; obs_we = bus_we;
            end
            if (bus_req)   obs_req   = 1'b1;
            if (align_err) obs_align = 1'b1;
            if (bus_err)   obs_berr  = 1'b1;
            obs_data = mem_read_data;
        end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; mem_addr = '0; mem_write_data = '0;
        mem_wr = 1'b0; mem_sb = 1'b0; mem_sh = 1'b0; mem_lb = 1'b0; mem_lh = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        @(negedge clk);
        check("rst mem_read_data", mem_read_data, 32'h0);
        check("rst busy",      32'(busy),      32'h0);
        check("rst align_err", 32'(align_err), 32'h0);
        check("rst bus_err",   32'(bus_err),   32'h0);
        check("rst bus_req",   32'(bus_req),   32'h0);
        check("rst bus_we",    32'(bus_we),    32'h0);
        check("rst bus_addr",  32'(bus_addr),  32'h0);
        check("rst bus_wdata", bus_wdata,      32'h0);
        check("rst bus_be",    32'(bus_be),    32'h0);

        run_txn(32'h100, 32'h0, 1'b0, 2, 32'hDEAD_BEEF, 1);
        check("lw addr",  32'(obs_addr), 32'h40);
        check("lw be",    32'(obs_be),   32'hF);
        check("lw busy cycles", 32'(obs_busy), 32'd2);
        check("lw data",  obs_data, 32'hDEAD_BEEF);

        run_txn(32'h103, 32'h0000_00A5, 1'b1, 0, 32'h0, 1);
        check("sb be",    32'(obs_be), 32'h1);
        check("sb wdata", obs_wdata,   32'hA5A5_A5A5);
        check("sb we",    32'(obs_we), 32'h1);

        run_txn(32'h101, 32'h0, 1'b0, 0, 32'h1122_3344, 2);
        check("lb data", obs_data, 32'h0000_0022);

        run_txn(32'h102, 32'h0, 1'b0, 1, 32'h1122_ABCD, 1);
        check("lh data", obs_data, 32'h0000_ABCD);

        run_txn(32'h101, 32'h0, 1'b0, 1, 32'h5555_5555, 1);
        check("lh misaligned align_err", 32'(obs_align), 32'h1);
        check("lh misaligned bus_req",   32'(obs_req),   32'h0);
        check("lh misaligned data",      obs_data,       32'h0);

        run_txn(32'h104, 32'h0, 1'b0, 2, 32'h1234_5678, L + 1);
        check("timeout bus_err",     32'(obs_berr), 32'h1);
        check("timeout data",        obs_data,      32'h0);
        check("timeout busy cycles", 32'(obs_busy), 32'd5);

        run_txn(32'h108, 32'h0, 1'b0, 2, 32'hCAFE_F00D, L);
        check("ack at limit bus_err", 32'(obs_berr), 32'h0);
        check("ack at limit data",    obs_data,      32'hCAFE_F00D);

        // Reset in the middle of an access.
        @(posedge clk); #1;
        req_valid = 1'b1; mem_addr = 32'h200; mem_wr = 1'b0;
        mem_sb = 1'b0; mem_sh = 1'b0; mem_lb = 1'b0; mem_lh = 1'b0; bus_ack = 1'b0;
        @(posedge clk); #1;
        check("pre-reset bus_req", 32'(bus_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("async reset bus_req", 32'(bus_req), 32'h0);
        check("async reset busy",    32'(busy),    32'h0);
        req_valid = 1'b0;
        @(posedge clk); #3 reset = 1'b1;
        exp_rdata = '0;
        @(negedge clk);
        check("post-reset data", mem_read_data, 32'h0);
        check("post-reset busy", 32'(busy),     32'h0);
        run_txn(32'h10C, 32'h0, 1'b0, 2, 32'h0BAD_C0DE, 1);
        check("post-reset lw data", obs_data, 32'h0BAD_C0DE);

        for (int i = 0; i < 400; i++) begin
            run_txn($urandom(), $urandom(), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), $urandom(), int'($urandom_range(1, L + 1)));
            repeat (int'($urandom_range(0, 2))) idle_cycle();
        end
        repeat (3) idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
